memory_access_sequencer: RTL and testbench
==========================================

# memory_access_sequencer

Single-port RAM access sequencer for the CPU. It shares the one RAM between the instruction-fetch path and the data path (GETDATA/SETDATA on the data segment, PUSH/POP on the stack segment), and owns the stack pointer. It drives the segment-select and offset inputs of the memory address creator, which prefixes the CS/DS/SS segment bits from the current IR. It also drives the RAM read/write strobes and returns data to the requester through a req/ack handshake.

## Interface
- addressLegth, default 10: full RAM address width; 2 segment-prefix bits plus an 8-bit offset.
- dataLength, default 16: RAM word width, equal to instructionLength.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- fetch_req  input  1  instruction-fetch request; level signal, held until fetch_ack.
- fetch_addr  input  addressLegth-2  PC offset within the code segment.
- fetch_ack  output  1  one-cycle pulse; instr_data is valid in the same cycle.
- instr_data  output  dataLength  registered fetched word.
- data_req  input  1  data request; level signal, held until data_ack.
- data_op  input  2  00 GETDATA, 01 SETDATA, 10 PUSH, 11 POP.
- data_addr  input  addressLegth-2  data-segment offset; ignored for PUSH/POP.
- data_wdata  input  dataLength  write data for SETDATA/PUSH.
- data_ack  output  1  one-cycle pulse on completion, including faulted operations.
- data_rdata  output  dataLength  registered read word for GETDATA/POP.
- stack_fault  output  1  pulses together with data_ack when a PUSH is made to a full stack or a POP to an empty stack.
- sp  output  addressLegth-2  current stack pointer (next free slot).
- mem_select_code_segment  output  1  to the address creator; 1 selects CS.
- mem_offset  output  addressLegth-2  to the address creator's in_ADDR.
- mem_re  output  1  RAM read strobe.
- mem_we  output  1  RAM write strobe.
- mem_wdata  output  dataLength  RAM write data.
- mem_rdata  input  dataLength  RAM read data, valid one cycle after mem_re.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- **IDLE:** sample the requests.
  - If only one of fetch_req/data_req is high, grant it.
  - If both are high, grant the requester that was not granted last (round-robin). The last-grant bit resets to "fetch", so data wins the first tie.
  - Latch the op, offset and wdata, then go to ACCESS.
  - If neither request is high, stay in IDLE.
- **ACCESS:** exactly one cycle; the strobes are driven from the latched request.
  - fetch: mem_select_code_segment=1, mem_offset=fetch_addr, mem_re=1.
  - GETDATA: select=0, offset=data_addr, mem_re=1.
  - SETDATA: select=0, offset=data_addr, mem_we=1, mem_wdata=data_wdata.
  - PUSH, not full: select=0, offset=sp, mem_we=1, mem_wdata=data_wdata; sp<=sp-1 at the end of the cycle.
  - POP, not empty: select=0, offset=sp+1, mem_re=1; sp<=sp+1 at the end of the cycle.
  - Faulted PUSH/POP: no strobe, sp unchanged.
  - Go to RESP.
- **RESP:** one cycle.
  - For reads, capture mem_rdata into instr_data (fetch) or data_rdata (GETDATA/POP).
  - Pulse the granted ack, plus stack_fault if the operation faulted.
  - Go to IDLE.
- **Stack:** full-descending with sp pointing to the next free slot.
  - Empty when sp is all ones; full when sp=0. Usable depth is 2^(addressLegth-2)-1.
  - sp arithmetic is modulo 2^(addressLegth-2). It never actually wraps because the full/empty checks prevent it.
- **Outputs outside ACCESS:** mem_re=0, mem_we=0, mem_select_code_segment=1, mem_offset=fetch_addr, mem_wdata=0.
- Requests that change while not in IDLE are ignored. The requester must hold req until its ack and deassert it in the cycle after the ack.
- Both reads and writes complete with the same latency.

## Timing
- Reset values:
  - state=IDLE, sp=all ones (0xFF at default width).
  - instr_data=0, data_rdata=0.
  - acks=0, stack_fault=0, mem_re=0, mem_we=0, mem_select_code_segment=1, mem_offset=0 (fetch_addr driven).
- Latency: a request sampled high at edge n gives ACCESS during cycle n+1 and an ack pulse during cycle n+2. The earliest next grant is at the edge ending cycle n+2. Peak throughput is one access per 3 cycles.
- Ack, stack_fault, instr_data and data_rdata are registered outputs; data is valid in the ack cycle and holds until the next read of the same type.
- If rst_n is asserted mid-operation (ACCESS or RESP), strobes drop immediately and asynchronously. No ack is issued, sp returns to all ones, and the aborted write may or may not have reached RAM.
- Simultaneous fetch and data requests in IDLE are resolved in the same cycle. The losing requester is served in the next IDLE, so neither starves.

## Test plan
- **Reset:** assert rst_n=0 mid-ACCESS -> mem_we=0 and mem_re=0 in the same cycle; after release sp=0xFF, no ack, state IDLE.
- **Fetch:** fetch_req with fetch_addr=0x12, mem_rdata=0xABCD one cycle after mem_re -> mem_select_code_segment=1 and offset 0x12 in ACCESS; fetch_ack with instr_data=0xABCD two cycles after the request.
- **Stack round-trip:**
  - PUSH 0x1111 -> write at offset 0xFF, sp=0xFE.
  - PUSH 0x2222 -> write at offset 0xFE, sp=0xFD.
  - POP -> read at offset 0xFE, data_rdata=0x2222, sp=0xFE.
- **Stack faults:**
  - POP at reset (sp=0xFF) -> data_ack with stack_fault=1, no mem_re, sp unchanged.
  - 255 PUSHes bring sp to 0; a 256th PUSH -> stack_fault=1, no mem_we.
- **Arbitration:** fetch_req and data_req (SETDATA, addr 0x40, wdata 0x5A5A) held high together from reset:
  - data is granted first: mem_we with select=0 and offset 0x40.
  - fetch is granted next.
  - Acks alternate while both stay high.
- **Back-to-back throughput:** data_req GETDATA held continuously -> data_ack pulses every 3 cycles, with mem_re only in the ACCESS cycle.

Source files
------------

// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer
//   Shares one single-port RAM between instruction fetch and the data path
//   (GETDATA/SETDATA on DS, PUSH/POP on SS). Owns the descending stack pointer.
//   Every access takes IDLE -> ACCESS -> RESP. Fetch and data requests that
//   arrive together are resolved round-robin.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   fetch_req/addr -> fetch_ack        instruction fetch handshake, instr_data
//   data_req/op/addr/wdata -> data_ack data handshake, data_rdata, stack_fault
//   sp                                 stack pointer (next free slot)
//   mem_select_code_segment/mem_offset to the address creator
//   mem_re/mem_we/mem_wdata/mem_rdata  RAM strobes and data
module memory_access_sequencer #(
    parameter int addressLegth = 10,
    parameter int dataLength   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_req,
    input  logic [addressLegth-3:0] fetch_addr,
    output logic                    fetch_ack,
    output logic [dataLength-1:0]   instr_data,
    input  logic                    data_req,
    input  logic [1:0]              data_op,
    input  logic [addressLegth-3:0] data_addr,
    input  logic [dataLength-1:0]   data_wdata,
    output logic                    data_ack,
    output logic [dataLength-1:0]   data_rdata,
    output logic                    stack_fault,
    output logic [addressLegth-3:0] sp,
    output logic                    mem_select_code_segment,
    output logic [addressLegth-3:0] mem_offset,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [dataLength-1:0]   mem_wdata,
    input  logic [dataLength-1:0]   mem_rdata
);
    localparam int OW = addressLegth - 2;

    localparam logic [1:0] OP_GET  = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                r_state, w_next;
    logic                  r_last_fetch;  // 1: fetch was granted last
    logic                  r_is_fetch;    // current grant belongs to fetch
    logic [1:0]            r_op;
    logic [OW-1:0]         r_offset;
    logic [dataLength-1:0] r_wdata;
    logic [OW-1:0]         r_sp;
    logic                  r_fetch_ack, r_data_ack, r_fault, r_read;
    logic [dataLength-1:0] r_instr, r_rdata;

    logic w_grant_fetch, w_grant_any, w_fault;

    // Fetch wins when it is alone or when data had the last grant.
    assign w_grant_any   = fetch_req | data_req;
    assign w_grant_fetch = fetch_req & (~data_req | ~r_last_fetch);

    // sp is stable from grant through ACCESS, so the fault is decided here.
    assign w_fault = ~r_is_fetch &
                     (((r_op == OP_PUSH) && (r_sp == '0)) ||
                      ((r_op == OP_POP)  && (r_sp == '1)));

    always_comb begin
        w_next                  = r_state;
        mem_select_code_segment = 1'b1;
        mem_offset              = fetch_addr;
        mem_re                  = 1'b0;
        mem_we                  = 1'b0;
        mem_wdata               = '0;
        case (r_state)
            S_IDLE: if (w_grant_any) w_next = S_ACCESS;
            S_ACCESS: begin
                w_next = S_RESP;
                if (r_is_fetch) begin
                    mem_offset = r_offset;
                    mem_re     = 1'b1;
                end else if (!w_fault) begin
                    mem_select_code_segment = 1'b0;
                    case (r_op)
                        OP_GET: begin
                            mem_offset = r_offset;
                            mem_re     = 1'b1;
                        end
                        OP_SET: begin
                            mem_offset = r_offset;
                            mem_we     = 1'b1;
                            mem_wdata  = r_wdata;
                        end
                        OP_PUSH: begin
                            mem_offset = r_sp;
                            mem_we     = 1'b1;
                            mem_wdata  = r_wdata;
                        end
                        default: begin
                            mem_offset = r_sp + OW'(1);
                            mem_re     = 1'b1;
                        end
                    endcase
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_fetch <= 1'b1;
            r_is_fetch   <= 1'b0;
            r_op         <= OP_GET;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_sp         <= '1;
            r_fetch_ack  <= 1'b0;
            r_data_ack   <= 1'b0;
            r_fault      <= 1'b0;
            r_read       <= 1'b0;
            r_instr      <= '0;
            r_rdata      <= '0;
        end else begin
            r_state     <= w_next;
            r_fetch_ack <= 1'b0;
            r_data_ack  <= 1'b0;
            r_fault     <= 1'b0;
            if (r_state == S_IDLE && w_grant_any) begin
                r_is_fetch   <= w_grant_fetch;
                r_last_fetch <= w_grant_fetch;
                r_op         <= data_op;
                r_offset     <= w_grant_fetch ? fetch_addr : data_addr;
                r_wdata      <= data_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_fetch_ack <= r_is_fetch;
                r_data_ack  <= ~r_is_fetch;
                r_fault     <= w_fault;
                r_read      <= mem_re;
                if (!r_is_fetch && !w_fault) begin
                    if (r_op == OP_PUSH) r_sp <= r_sp - OW'(1);
                    if (r_op == OP_POP)  r_sp <= r_sp + OW'(1);
                end
            end
            if (r_state == S_RESP && r_read) begin
                if (r_is_fetch) r_instr <= mem_rdata;
                else            r_rdata <= mem_rdata;
            end
        end
    end

    // RAM data arrives during RESP; forward it so it is valid with the ack,
    // then the captured copy holds until the next read of the same type.
    assign instr_data  = (r_state == S_RESP && r_read &&  r_is_fetch) ? mem_rdata : r_instr;
    assign data_rdata  = (r_state == S_RESP && r_read && !r_is_fetch) ? mem_rdata : r_rdata;
    assign fetch_ack   = r_fetch_ack;
    assign data_ack    = r_data_ack;
    assign stack_fault = r_fault;
    assign sp          = r_sp;
endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb_memory_access_sequencer
//   Directed bench: a small synchronous RAM model answers the strobes; each
//   scenario task drives requests on the falling edge and checks there.
module tb_memory_access_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ack;
    logic [15:0] instr_data;
    logic        data_req;
    logic [1:0]  data_op;
    logic [7:0]  data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        stack_fault;
    logic [7:0]  sp;
    logic        mem_select_code_segment;
    logic [7:0]  mem_offset;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    logic [15:0] ram [0:511];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_access_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .instr_data(instr_data),
        .data_req(data_req), .data_op(data_op), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .stack_fault(stack_fault), .sp(sp),
        .mem_select_code_segment(mem_select_code_segment), .mem_offset(mem_offset),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model indexed by {segment select, offset}; code word preloaded in reset.
    always @(posedge clk) begin
        if (!rst_n) ram[{1'b1, 8'h12}] <= 16'hABCD;
        else begin
            if (mem_we) ram[{mem_select_code_segment, mem_offset}] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[{mem_select_code_segment, mem_offset}];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called on an IDLE falling edge; returns on the ACCESS falling edge.
    task automatic issue_data(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd);
        data_op = op; data_addr = addr; data_wdata = wd; data_req = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (sp !== 8'hFF) begin failures++; $display("FAIL rst_sp got=%h exp=ff", sp); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {mem_re, mem_we}); end
        checks++; if (mem_select_code_segment !== 1'b1) begin failures++; $display("FAIL rst_sel got=%b exp=1", mem_select_code_segment); end
        checks++; if (mem_offset !== 8'h00) begin failures++; $display("FAIL rst_offset got=%h exp=00", mem_offset); end
        checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        checks++; if ({fetch_ack, data_ack, stack_fault} !== 3'b000) begin failures++; $display("FAIL rst_acks got=%b exp=000", {fetch_ack, data_ack, stack_fault}); end
        checks++; if ({instr_data, data_rdata} !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {instr_data, data_rdata}); end
        // One complete PUSH, then abort a second one inside ACCESS.
        issue_data(2'b10, 8'h00, 16'h7777);
        @(negedge clk); data_req = 1'b0;
        @(negedge clk);
        checks++; if (sp !== 8'hFE) begin failures++; $display("FAIL rst_push_sp got=%h exp=fe", sp); end
        issue_data(2'b10, 8'h00, 16'h8888);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_pre_we got=%b exp=1", mem_we); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL rst_async_strobes got=%b exp=00", {mem_re, mem_we}); end
        data_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++; if (sp !== 8'hFF) begin failures++; $display("FAIL rst_abort_sp got=%h exp=ff", sp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({fetch_ack, data_ack, mem_re, mem_we} !== 4'b0000) begin
                failures++; $display("FAIL rst_no_ack cyc=%0d got=%b exp=0000", i, {fetch_ack, data_ack, mem_re, mem_we}); end
        end
    endtask

    task automatic test_fetch;
        fetch_addr = 8'h12; fetch_req = 1'b1;
        @(negedge clk);
        checks++; if ({mem_select_code_segment, mem_re, mem_we} !== 3'b110) begin failures++; $display("FAIL fetch_strobes got=%b exp=110", {mem_select_code_segment, mem_re, mem_we}); end
        checks++; if (mem_offset !== 8'h12) begin failures++; $display("FAIL fetch_offset got=%h exp=12", mem_offset); end
        checks++; if (fetch_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack got=%b exp=0", fetch_ack); end
        @(negedge clk);
        checks++; if ({fetch_ack, data_ack} !== 2'b10) begin failures++; $display("FAIL fetch_ack got=%b exp=10", {fetch_ack, data_ack}); end
        checks++; if (instr_data !== 16'hABCD) begin failures++; $display("FAIL fetch_data got=%h exp=abcd", instr_data); end
        fetch_req = 1'b0;
        @(negedge clk);
        checks++; if (fetch_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got=%b exp=0", fetch_ack); end
        checks++; if (instr_data !== 16'hABCD) begin failures++; $display("FAIL fetch_hold got=%h exp=abcd", instr_data); end
    endtask

    task automatic test_stack;
        issue_data(2'b10, 8'h00, 16'h1111);
        checks++; if ({mem_we, mem_select_code_segment, mem_offset, mem_wdata} !== {1'b1, 1'b0, 8'hFF, 16'h1111}) begin
            failures++; $display("FAIL push1_access got=%b/%b/%h/%h exp=1/0/ff/1111", mem_we, mem_select_code_segment, mem_offset, mem_wdata); end
        @(negedge clk);
        checks++; if ({data_ack, stack_fault, sp} !== {2'b10, 8'hFE}) begin failures++; $display("FAIL push1_resp got=%b%b/%h exp=10/fe", data_ack, stack_fault, sp); end
        data_req = 1'b0; @(negedge clk);
        issue_data(2'b10, 8'h00, 16'h2222);
        checks++; if ({mem_we, mem_offset, mem_wdata} !== {1'b1, 8'hFE, 16'h2222}) begin
            failures++; $display("FAIL push2_access got=%b/%h/%h exp=1/fe/2222", mem_we, mem_offset, mem_wdata); end
        @(negedge clk);
        checks++; if (sp !== 8'hFD) begin failures++; $display("FAIL push2_sp got=%h exp=fd", sp); end
        data_req = 1'b0; @(negedge clk);
        issue_data(2'b11, 8'h00, 16'h0);
        checks++; if ({mem_re, mem_we, mem_select_code_segment, mem_offset} !== {3'b100, 8'hFE}) begin
            failures++; $display("FAIL pop1_access got=%b%b%b/%h exp=100/fe", mem_re, mem_we, mem_select_code_segment, mem_offset); end
        @(negedge clk);
        checks++; if ({data_ack, data_rdata, sp} !== {1'b1, 16'h2222, 8'hFE}) begin
            failures++; $display("FAIL pop1_resp got=%b/%h/%h exp=1/2222/fe", data_ack, data_rdata, sp); end
        data_req = 1'b0; @(negedge clk);
        issue_data(2'b11, 8'h00, 16'h0);
        checks++; if (mem_offset !== 8'hFF) begin failures++; $display("FAIL pop2_offset got=%h exp=ff", mem_offset); end
        @(negedge clk);
        checks++; if ({data_rdata, sp} !== {16'h1111, 8'hFF}) begin failures++; $display("FAIL pop2_resp got=%h/%h exp=1111/ff", data_rdata, sp); end
        data_req = 1'b0; @(negedge clk);
    endtask

    task automatic test_stack_fault;
        int bad;
        issue_data(2'b11, 8'h00, 16'h0);
        checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL pop_empty_strobes got=%b exp=00", {mem_re, mem_we}); end
        @(negedge clk);
        checks++; if ({data_ack, stack_fault, sp} !== {2'b11, 8'hFF}) begin failures++; $display("FAIL pop_empty_resp got=%b%b/%h exp=11/ff", data_ack, stack_fault, sp); end
        checks++; if (data_rdata !== 16'h1111) begin failures++; $display("FAIL pop_empty_hold got=%h exp=1111", data_rdata); end
        data_req = 1'b0; @(negedge clk);
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            issue_data(2'b10, 8'h00, 16'(i));
            if (mem_we !== 1'b1) bad++;
            @(negedge clk);
            if (stack_fault !== 1'b0 || data_ack !== 1'b1) bad++;
            data_req = 1'b0; @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL fill_stack bad=%0d exp=0", bad); end
        checks++; if (sp !== 8'h00) begin failures++; $display("FAIL fill_sp got=%h exp=00", sp); end
        issue_data(2'b10, 8'h00, 16'hDEAD);
        checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL push_full_strobes got=%b exp=00", {mem_re, mem_we}); end
        @(negedge clk);
        checks++; if ({data_ack, stack_fault, sp} !== {2'b11, 8'h00}) begin failures++; $display("FAIL push_full_resp got=%b%b/%h exp=11/00", data_ack, stack_fault, sp); end
        data_req = 1'b0; @(negedge clk);
        issue_data(2'b11, 8'h00, 16'h0);
        checks++; if ({mem_re, mem_offset} !== {1'b1, 8'h01}) begin failures++; $display("FAIL pop_full_access got=%b/%h exp=1/01", mem_re, mem_offset); end
        @(negedge clk);
        checks++; if ({stack_fault, data_rdata, sp} !== {1'b0, 16'h00FE, 8'h01}) begin
            failures++; $display("FAIL pop_full_resp got=%b/%h/%h exp=0/00fe/01", stack_fault, data_rdata, sp); end
        data_req = 1'b0; @(negedge clk);
    endtask

    task automatic test_arbitration;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        fetch_addr = 8'h33; fetch_req = 1'b1;
        data_op = 2'b01; data_addr = 8'h40; data_wdata = 16'h5A5A; data_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            checks++; if ({mem_we, mem_re, mem_select_code_segment, mem_offset} !== {3'b100, 8'h40}) begin
                failures++; $display("FAIL arb_data_access r=%0d got=%b%b%b/%h exp=100/40", r, mem_we, mem_re, mem_select_code_segment, mem_offset); end
            @(negedge clk);
            checks++; if ({data_ack, fetch_ack} !== 2'b10) begin failures++; $display("FAIL arb_data_ack r=%0d got=%b exp=10", r, {data_ack, fetch_ack}); end
            @(negedge clk);
            @(negedge clk);
            checks++; if ({mem_re, mem_we, mem_select_code_segment, mem_offset} !== {3'b101, 8'h33}) begin
                failures++; $display("FAIL arb_fetch_access r=%0d got=%b%b%b/%h exp=101/33", r, mem_re, mem_we, mem_select_code_segment, mem_offset); end
            @(negedge clk);
            checks++; if ({fetch_ack, data_ack} !== 2'b10) begin failures++; $display("FAIL arb_fetch_ack r=%0d got=%b exp=10", r, {fetch_ack, data_ack}); end
            if (r == 2) begin fetch_req = 1'b0; data_req = 1'b0; end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        issue_data(2'b00, 8'h40, 16'h0);
        // issue_data already stepped into the first ACCESS (i=1).
        checks++; if ({mem_re, data_ack} !== 2'b10) begin failures++; $display("FAIL b2b cyc=1 got=%b exp=10", {mem_re, data_ack}); end
        for (int i = 2; i <= 29; i++) begin
            @(negedge clk);
            checks++; if ({mem_re, data_ack} !== {(i % 3 == 1), (i % 3 == 2)}) begin
                failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, {mem_re, data_ack}, {(i % 3 == 1), (i % 3 == 2)}); end
        end
        checks++; if (data_rdata !== 16'h5A5A) begin failures++; $display("FAIL b2b_data got=%h exp=5a5a", data_rdata); end
        data_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 8'h00;
        data_req = 1'b0; data_op = 2'b00; data_addr = 8'h00; data_wdata = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_fetch;
        test_stack;
        test_stack_fault;
        test_arbitration;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
